// File: rtl/dct_coeff_reader.sv
// dct_coeff_reader
//   Reads one 8-coefficient DCT block from an external result memory and
//   quantizes each coefficient by multiplying it with a per-index reciprocal
//   (Q0.16), rounding half up and saturating to OUT_WIDTH. The quantized
//   coefficients are emitted on a valid/ready stream, one per handshake.
//
// Ports
//   clock, reset              : single clock, synchronous active-high reset
//   start                     : launch one block (honoured only when idle)
//   fetch_addr/clk/data       : result-memory read port (1-cycle read latency)
//   qtab_wren/waddr/wdata     : reciprocal table write port (ignored while busy)
//   out_valid/ready/data/index/last : quantized coefficient stream
//   busy, done                : block in progress / one-cycle completion pulse
module dct_coeff_reader #(
    parameter int COEFF_WIDTH = 16,
    parameter int RECIP_WIDTH = 16,
    parameter int OUT_WIDTH   = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic [2:0]             fetch_addr,
    output logic                   fetch_clk,
    input  logic [COEFF_WIDTH-1:0] fetch_data,
    input  logic                   qtab_wren,
    input  logic [2:0]             qtab_waddr,
    input  logic [RECIP_WIDTH-1:0] qtab_wdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [2:0]             out_index,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_EMIT = 2'd3;

    // Signed coefficient times zero-extended reciprocal.
    localparam int PW = COEFF_WIDTH + RECIP_WIDTH + 1;
    localparam logic signed [PW-1:0] RND  = PW'(1) << (RECIP_WIDTH - 1);
    localparam logic signed [PW-1:0] OMAX = PW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] OMIN = ~OMAX;

    logic [1:0]             state;
    logic [2:0]             index;
    logic [RECIP_WIDTH-1:0] qtab [8];

    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   scaled;
    logic [OUT_WIDTH-1:0]   quant;

    // The memory runs on our clock; hand it straight through.
    assign fetch_clk = clock;

    always_comb begin
        prod   = $signed(fetch_data) * $signed({1'b0, qtab[index]});
        scaled = (prod + RND) >>> RECIP_WIDTH;
        quant  = scaled[OUT_WIDTH-1:0];
        if (scaled > OMAX)
            quant = OMAX[OUT_WIDTH-1:0];
        else if (scaled < OMIN)
            quant = OMIN[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            index      <= '0;
            fetch_addr <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < 8; i++)
                qtab[i] <= '1;
        end else begin
            done <= 1'b0;

            // busy is the registered flag, so a write in the same idle cycle
            // as start lands before the block reaches MUL.
            if (qtab_wren && !busy)
                qtab[qtab_waddr] <= qtab_wdata;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        index      <= '0;
                        fetch_addr <= '0;
                        busy       <= 1'b1;
                        state      <= S_READ;
                    end
                end
                // Memory samples fetch_addr at the end of READ; data is
                // present during MUL.
                S_READ: state <= S_MUL;
                S_MUL: begin
                    out_data  <= quant;
                    out_index <= index;
                    out_last  <= (index == 3'd7);
                    out_valid <= 1'b1;
                    state     <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (index == 3'd7) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            index      <= index + 3'd1;
                            fetch_addr <= index + 3'd1;
                            state      <= S_READ;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_coeff_reader.sv
module tb_dct_coeff_reader;
    localparam int CW = 16;
    localparam int RW = 16;
    localparam int OW = 12;

    logic          clock = 1'b0;
    logic          reset, start, qtab_wren, out_ready;
    logic [2:0]    qtab_waddr, fetch_addr, out_index;
    logic [RW-1:0] qtab_wdata;
    logic [CW-1:0] fetch_data;
    logic          fetch_clk, out_valid, out_last, busy, done;
    logic [OW-1:0] out_data;

    always #5 clock = ~clock;

    dct_coeff_reader #(.COEFF_WIDTH(CW), .RECIP_WIDTH(RW), .OUT_WIDTH(OW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .fetch_addr(fetch_addr), .fetch_clk(fetch_clk), .fetch_data(fetch_data),
        .qtab_wren(qtab_wren), .qtab_waddr(qtab_waddr), .qtab_wdata(qtab_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    // Result memory model: synchronous read, data one cycle after address.
    logic [CW-1:0] mem  [8];
    logic [RW-1:0] mtab [8];
    always @(posedge fetch_clk) fetch_data <= mem[fetch_addr];

    int total = 0;
    int bad   = 0;

    logic [OW-1:0] got_d [8];
    logic [2:0]    got_i [8];
    logic          got_l [8];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: round(coeff * recip / 65536) half up, then clamp.
    function automatic int quant(input logic [CW-1:0] d, input logic [RW-1:0] r);
        longint p;
        p = longint'($signed(d)) * longint'(r) + 64'sd32768;
        p = p >>> 16;
        if (p > 2047)  p = 2047;
        if (p < -2048) p = -2048;
        return int'(p);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_tab(input logic [2:0] a, input logic [RW-1:0] d);
        qtab_wren = 1'b1; qtab_waddr = a; qtab_wdata = d;
        tick();
        qtab_wren = 1'b0;
        mtab[a] = d;
    endtask

    // Runs one block and checks it against the model. Cycle n counts edges
    // after the start edge; out_valid is first seen after edge 2 (high in
    // the third clock period counting the start cycle) and done after edge
    // 24 plus one per cycle of backpressure.
    task automatic run_block(input int stall_idx, input int stall_len, input bit rnd,
                             input bit disturb, input bit wr_start,
                             input logic [2:0] wa, input logic [RW-1:0] wd,
                             input string tag);
        int n, first, hs, stalled, extra;
        bit was_stall;
        logic [OW-1:0] hold_d;
        logic [2:0]    hold_i;
        logic [RW-1:0] snap [8];
        if (wr_start) begin
            qtab_wren = 1'b1; qtab_waddr = wa; qtab_wdata = wd; mtab[wa] = wd;
        end
        for (int i = 0; i < 8; i++) snap[i] = mtab[i];
        start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; qtab_wren = 1'b0;
        check({tag, " busy_after_start"}, busy, 1);
        n = 0; first = -1; hs = 0; stalled = 0; extra = 0; was_stall = 0;
        hold_d = '0; hold_i = '0;
        while (!done && n < 300) begin
            if (out_valid && first < 0) first = n;
            if (was_stall) begin
                check({tag, " stall_data"}, out_data, hold_d);
                check({tag, " stall_index"}, out_index, hold_i);
                check({tag, " stall_fetch_addr"}, fetch_addr, hold_i);
                check({tag, " stall_valid"}, out_valid, 1);
            end
            was_stall = 0;
            if (disturb && n == 5) begin
                start = 1'b1; qtab_wren = 1'b1; qtab_waddr = 3'd2; qtab_wdata = 16'h1234;
            end else begin
                start = 1'b0; qtab_wren = 1'b0;
            end
            if (out_valid && int'(out_index) == stall_idx && stalled < stall_len) begin
                out_ready = 1'b0; stalled++;
            end else if (rnd) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b1;
            if (out_valid && !out_ready) begin
                extra++; was_stall = 1; hold_d = out_data; hold_i = out_index;
            end
            if (out_valid && out_ready) begin
                if (hs < 8) begin
                    got_d[hs] = out_data; got_i[hs] = out_index; got_l[hs] = out_last;
                end
                hs++;
            end
            tick(); n++;
        end
        start = 1'b0; qtab_wren = 1'b0; out_ready = 1'b1;
        check({tag, " done_latency"}, n, 24 + extra);
        check({tag, " first_valid"}, first, 2);
        check({tag, " handshakes"}, hs, 8);
        for (int k = 0; k < 8 && k < hs; k++) begin
            check({tag, " data"}, $signed(got_d[k]), quant(mem[k], snap[k]));
            check({tag, " index"}, got_i[k], k);
            check({tag, " last"}, got_l[k], (k == 7) ? 1 : 0);
        end
        check({tag, " busy_at_done"}, busy, 0);
        tick();
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " idle_after"}, busy, 0);
    endtask

    typedef struct {
        logic [7:0][CW-1:0] m;
        logic [7:0][RW-1:0] t;
        logic [7:0][OW-1:0] e;
        bit                 wr;
        string              name;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int m_a [8] = '{9, 9, 9, 9, -1, -3, -5, -7};
        int e_a [8] = '{5, 5, 5, 5, 0, -1, -2, -3};
        int cnt;

        // Fixed vectors: reset table, half table, saturation.
        for (int i = 0; i < 8; i++) begin
            vecs[0].m[i] = CW'(m_a[i]); vecs[0].t[i] = 16'hFFFF; vecs[0].e[i] = OW'(m_a[i]);
            vecs[1].m[i] = CW'(m_a[i]); vecs[1].t[i] = 16'h8000; vecs[1].e[i] = OW'(e_a[i]);
            vecs[2].m[i] = '0;          vecs[2].t[i] = 16'hFFFF; vecs[2].e[i] = '0;
        end
        vecs[2].m[0] = 16'h7FFF; vecs[2].e[0] = 12'h7FF;
        vecs[2].m[1] = 16'h8000; vecs[2].e[1] = 12'h800;
        vecs[0].wr = 0; vecs[0].name = "tab_reset";
        vecs[1].wr = 1; vecs[1].name = "tab_half";
        vecs[2].wr = 1; vecs[2].name = "saturate";

        reset = 1'b1; start = 1'b0; qtab_wren = 1'b0; qtab_waddr = '0;
        qtab_wdata = '0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin mem[i] = '0; mtab[i] = 16'hFFFF; end
        tick(); tick();
        check("rst out_valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst fetch_addr", fetch_addr, 0);
        check("rst out_index", out_index, 0);
        check("rst out_data", out_data, 0);
        check("rst out_last", out_last, 0);

        // Reset wins over start in the same cycle.
        start = 1'b1;
        tick();
        check("rst_vs_start busy", busy, 0);
        reset = 1'b0; start = 1'b0;
        tick();
        check("rst_vs_start idle", busy, 0);

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 8; i++) mem[i] = vecs[v].m[i];
            if (vecs[v].wr)
                for (int i = 0; i < 8; i++) write_tab(3'(i), vecs[v].t[i]);
            run_block(-1, 0, 0, 0, 0, 3'd0, '0, vecs[v].name);
            for (int k = 0; k < 8; k++)
                check({vecs[v].name, " table_exp"}, got_d[k], vecs[v].e[k]);
        end

        // Backpressure at index 3 for 5 cycles.
        for (int i = 0; i < 8; i++) begin mem[i] = CW'(m_a[i]); write_tab(3'(i), 16'h8000); end
        run_block(3, 5, 0, 0, 0, 3'd0, '0, "stall");

        // start and table write while busy are ignored; next block proves
        // the table kept its contents.
        run_block(-1, 0, 0, 1, 0, 3'd0, '0, "disturb");
        mem[2] = 16'd1000;
        run_block(-1, 0, 0, 0, 0, 3'd0, '0, "tab_kept");
        check("tab_kept entry2", $signed(got_d[2]), 500);

        // Table write in the same cycle as start is used by that block.
        mem[5] = 16'd400;
        run_block(-1, 0, 0, 0, 1, 3'd5, 16'h4000, "wr_with_start");
        check("wr_with_start entry5", $signed(got_d[5]), 100);

        // Reset mid-block at index 4.
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        while (!(out_valid && out_index == 3'd4) && cnt < 100) begin tick(); cnt++; end
        check("abort reached_idx4", out_index, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mtab[i] = 16'hFFFF;
        check("abort out_valid", out_valid, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort out_index", out_index, 0);
        check("abort out_data", out_data, 0);
        check("abort fetch_addr", fetch_addr, 0);
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (done || busy) cnt++;
            tick();
        end
        check("abort quiet", cnt, 0);
        run_block(-1, 0, 0, 0, 0, 3'd0, '0, "restart");

        // Random blocks with random tables and random backpressure.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) begin
                if (r == 5) mem[i] = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
                else mem[i] = CW'($urandom());
            end
            if (r % 2 == 0)
                for (int i = 0; i < 8; i++) write_tab(3'(i), RW'($urandom()));
            run_block(-1, 0, 1, 0, r == 1, 3'($urandom_range(0, 7)),
                      RW'($urandom()), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dct_coeff_reader.md
DCT_COEFF_READER -- requirements
Module: dct_coeff_reader

Interface
REQ-001 SHALL have parameter COEFF_WIDTH, default 16, meaning the width of a signed DCT coefficient held in result memory.
REQ-002 SHALL have parameter RECIP_WIDTH, default 16, meaning the width of an unsigned quantizer reciprocal in Q0.16 (value/65536).
REQ-003 SHALL have parameter OUT_WIDTH, default 12, meaning the width of a signed quantized output coefficient.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a request to read and quantize one 8-coefficient block.
REQ-007 SHALL have port fetch_addr, output, 3, the result-memory read address (registered).
REQ-008 SHALL have port fetch_clk, output, 1, the result-memory read clock, driven as a direct copy of clock.
REQ-009 SHALL have port fetch_data, input, COEFF_WIDTH, the result-memory read data, valid in the cycle after fetch_addr is sampled.
REQ-010 SHALL have ports qtab_wren (input, 1), qtab_waddr (input, 3) and qtab_wdata (input, RECIP_WIDTH), forming the reciprocal-table write port.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, OUT_WIDTH), out_index (output, 3) and out_last (output, 1), forming the output stream.
REQ-012 SHALL have ports busy (output, 1), high while a block is in progress, and done (output, 1), a one-cycle completion pulse.

Function
REQ-013 SHALL implement an FSM with the states IDLE, READ, MUL and EMIT.
REQ-014 IDLE, start=1: SHALL clear the index to 0, set fetch_addr=0 and go to READ; busy goes high in the same edge.
REQ-015 READ: SHALL hold fetch_addr=index for one cycle, then go to MUL.
REQ-016 MUL: SHALL register the quantized result of fetch_data×qtab[index] into out_data, and register index into out_index, then go to EMIT.
REQ-017 EMIT: SHALL assert out_valid=1 and set out_last=(index==7).
REQ-018 EMIT, on a handshake (out_valid&out_ready), with index<7: SHALL increment index, update fetch_addr and go to READ.
REQ-019 EMIT, on a handshake with index==7: SHALL go to IDLE, with busy=0 and done=1 for exactly one cycle.
REQ-020 Backpressure: while out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL remain stable and the FSM SHALL stay in EMIT.
REQ-021 Latency: the first out_valid SHALL appear 3 cycles after the start edge. With out_ready held high, each coefficient SHALL take 3 cycles, and done SHALL pulse 24 cycles after start.
REQ-022 start SHALL be ignored in every state other than IDLE.
REQ-023 Arithmetic: the product SHALL be the 33-bit signed product of fetch_data and the zero-extended reciprocal, with 2^15 added, arithmetically shifted right by 16 (round half up).
REQ-024 Saturation: a result outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] SHALL be clamped to the nearest bound (-2048 or 2047 at the defaults).
REQ-025 Table writes with qtab_wren=1 SHALL update the entry at qtab_waddr when busy=0, and SHALL be ignored when busy=1.
REQ-026 A table write and start in the same IDLE cycle SHALL both take effect, with the write visible to the block that start launches.
REQ-027 fetch_addr SHALL hold its last value outside the READ state.

Reset
REQ-028 Reset SHALL set: state=IDLE, index=0, fetch_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0.
REQ-029 Reset SHALL set every qtab entry to 16'hFFFF (approximately ×1).
REQ-030 Reset asserted mid-block SHALL abort the block, so that all outputs hold their reset values in the next cycle, with no done pulse.
REQ-031 Reset SHALL take priority over start, table writes and handshakes in the same cycle.

Verification
REQ-032 Memory {9,9,9,9,-1,-3,-5,-7}, table all 16'h8000, out_ready=1, start pulsed -> outputs {5,5,5,5,0,-1,-2,-3} with indices 0..7 and out_last on index 7 only; done at start+24.
REQ-033 Same block with table left at its reset value (16'hFFFF) -> outputs {9,9,9,9,-1,-3,-5,-7}.
REQ-034 Memory[0]=16'h7FFF, memory[1]=16'h8000, table 16'hFFFF -> out_data 12'h7FF then 12'h800 (saturated).
REQ-035 out_ready held low for 5 cycles at index 3 -> out_data and out_index stay stable, fetch_addr stays at 3, and done is delayed by exactly 5 cycles.
REQ-036 Reset asserted at index 4 -> out_valid=0 and busy=0 in the next cycle, no done pulse; a later start restarts from index 0.
REQ-037 start pulsed while busy, and a qtab write issued while busy -> no effect on the current block, and the table is unchanged afterwards.
